// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: datapath status in, pipeline sequencing out.
// The controller sits on the slave side; the datapath drives the master side.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  // Status from the datapath
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_redirect;
  logic             ex_memRead;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_usesRt;
  logic             wb_halt;

  // Sequencing controls to the datapath
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;

  // Status and statistics
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_redirect,
           ex_memRead, ex_rd, id_rs, id_rt, id_usesRt, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           halted, mem_timeout, stall_cnt, flush_cnt
  );

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_redirect,
           ex_memRead, ex_rd, id_rs, id_rt, id_usesRt, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           halted, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Central sequencer for the 5-stage pipeline: picks one action per cycle
// (halt, data freeze, redirect flush, load-use bubble, fetch bubble, advance),
// drives PC/latch enables and flushes from it, and keeps stall/flush
// statistics plus a sticky data-memory watchdog.
module hazard_controller #(
  parameter int CNT_W         = 16,
  parameter int DWAIT_TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                nRST,
  hazard_controller_if.slave  hz
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_e;

  typedef enum logic [2:0] {
    ACT_HALTED,   // already in HALT: hold everything
    ACT_HALT,     // halt reached WB: freeze and enter HALT
    ACT_FREEZE,   // data memory busy: freeze the whole pipe
    ACT_REDIRECT, // branch/jump resolved: flush the three younger stages
    ACT_BUBBLE,   // load-use: hold IF/ID and PC, inject a NOP into ID/EX
    ACT_IMISS,    // fetch not done: hold PC, inject a NOP into IF/ID
    ACT_ADVANCE   // normal flow
  } action_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(DWAIT_TIMEOUT);

  state_e           state_q, state_d;
  action_e          act;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] dwait_cnt_q, dwait_cnt_d;
  logic [CNT_W-1:0] dwait_inc;
  logic             dstall;
  logic             lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign dstall    = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
  assign lu        = hz.ex_memRead & (hz.ex_rd != 5'd0) &
                     ((hz.ex_rd == hz.id_rs) | (hz.id_usesRt & (hz.ex_rd == hz.id_rt)));
  assign dwait_inc = sat_inc(dwait_cnt_q);

  // Select this cycle's action in strict priority order.
  always_comb begin
    if (state_q == HALT)        act = ACT_HALTED;
    else if (hz.wb_halt)        act = ACT_HALT;
    else if (dstall)            act = ACT_FREEZE;
    else if (hz.mem_redirect)   act = ACT_REDIRECT;
    else if (lu)                act = ACT_BUBBLE;
    else if (!hz.ihit)          act = ACT_IMISS;
    else                        act = ACT_ADVANCE;
  end

  // Decode the action into PC/latch enables and flushes.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    hz.pc_en       = 1'b0;
    hz.ifid_en     = 1'b0;
    hz.idex_en     = 1'b0;
    hz.exmem_en    = 1'b0;
    hz.memwb_en    = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    case (act)
      ACT_REDIRECT: begin
        {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = '1;
        {hz.ifid_flush, hz.idex_flush, hz.exmem_flush}              = '1;
      end
      ACT_BUBBLE: begin
        {hz.idex_en, hz.exmem_en, hz.memwb_en} = '1;
        hz.idex_flush = 1'b1;
      end
      ACT_IMISS: begin
        {hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = '1;
        hz.ifid_flush = 1'b1;
      end
      ACT_ADVANCE: begin
        {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = '1;
      end
      default: ; // halted, halt entry and data freeze keep everything at 0
    endcase
  end

  // Next state, statistics and watchdog for the chosen action.
  always_comb begin
    state_d     = RUN;
    halted_d    = halted_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    dwait_cnt_d = '0;
    case (act)
      ACT_HALTED: begin
        state_d     = HALT;
        dwait_cnt_d = dwait_cnt_q;
      end
      ACT_HALT: begin
        state_d     = HALT;
        halted_d    = 1'b1;
        dwait_cnt_d = dwait_cnt_q;
      end
      ACT_FREEZE: begin
        state_d     = DWAIT;
        stall_cnt_d = sat_inc(stall_cnt_q);
        // Only cycles already spent waiting count toward the watchdog.
        if (state_q == DWAIT) begin
          dwait_cnt_d = dwait_inc;
          if (dwait_inc >= TIMEOUT) timeout_d = 1'b1;
        end
      end
      ACT_REDIRECT:          flush_cnt_d = sat_inc(flush_cnt_q);
      ACT_BUBBLE, ACT_IMISS: stall_cnt_d = sat_inc(stall_cnt_q);
      default: ;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      dwait_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      dwait_cnt_q <= dwait_cnt_d;
    end
  end

  assign hz.halted      = halted_q;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios followed by random traffic,
// all compared against a rule-level reference model of the sequencer.
module tb_hazard_controller;

  localparam int CW   = 4;
  localparam int TMO  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic CLK;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  hazard_controller_if #(.CNT_W(CW)) hif ();

  hazard_controller #(.CNT_W(CW), .DWAIT_TIMEOUT(TMO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (hif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: pipeline condition flags and plain integer statistics.
  bit m_halted, m_waiting, m_timeout;
  int m_stall, m_flush, m_wait_cycles;

  task automatic model_reset();
    m_halted = 0; m_waiting = 0; m_timeout = 0;
    m_stall = 0; m_flush = 0; m_wait_cycles = 0;
  endtask

  // Expected controls as {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl};
  // when commit is set the model also advances one clock.
  task automatic model_step(input bit commit, output logic [7:0] ctrl);
    bit busy, reads_rd, load_use;
    busy     = (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;
    reads_rd = (hif.ex_rd == hif.id_rs) || (hif.id_usesRt && hif.ex_rd == hif.id_rt);
    load_use = hif.ex_memRead && hif.ex_rd != 0 && reads_rd;
    if (m_halted || hif.wb_halt) begin
      ctrl = 8'b00000_000;
      if (commit) m_halted = 1;
    end else if (busy) begin
      ctrl = 8'b00000_000;
      if (commit) begin
        if (m_stall < MAXC) m_stall++;
        if (m_waiting) begin
          m_wait_cycles++;
          if (m_wait_cycles >= TMO) m_timeout = 1;
        end
        m_waiting = 1;
      end
    end else begin
      if (hif.mem_redirect) begin
        ctrl = 8'b11111_111;
        if (commit && m_flush < MAXC) m_flush++;
      end else if (load_use) begin
        ctrl = 8'b00111_010;
        if (commit && m_stall < MAXC) m_stall++;
      end else if (!hif.ihit) begin
        ctrl = 8'b01111_100;
        if (commit && m_stall < MAXC) m_stall++;
      end else begin
        ctrl = 8'b11111_000;
      end
      if (commit) begin
        m_waiting = 0;
        m_wait_cycles = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_ctrl();
    return {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
            hif.ifid_flush, hif.idex_flush, hif.exmem_flush};
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_halted"},  32'(hif.halted),      32'(m_halted));
    check({tag, "_timeout"}, 32'(hif.mem_timeout), 32'(m_timeout));
    check({tag, "_stall"},   32'(hif.stall_cnt),   32'(m_stall));
    check({tag, "_flush"},   32'(hif.flush_cnt),   32'(m_flush));
  endtask

  // One clock: controls checked mid-cycle, registers checked just after the edge.
  task automatic cycle(input string tag);
    logic [7:0] e;
    #1;
    model_step(1'b1, e);
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(e));
    @(posedge CLK);
    #1;
    check_regs(tag);
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse; released on the following falling edge.
  task automatic do_reset(input string tag);
    logic [7:0] e;
    nRST = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    model_step(1'b0, e);
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(e));
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic idle_inputs();
    hif.ihit = 1'b1; hif.dhit = 1'b0; hif.mem_dREN = 1'b0; hif.mem_dWEN = 1'b0;
    hif.mem_redirect = 1'b0; hif.ex_memRead = 1'b0; hif.ex_rd = 5'd0;
    hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_usesRt = 1'b0; hif.wb_halt = 1'b0;
  endtask

  task automatic random_inputs();
    hif.ihit         = ($urandom_range(0, 3) != 0);
    hif.dhit         = $urandom_range(0, 1) == 1;
    hif.mem_dREN     = ($urandom_range(0, 3) == 0);
    hif.mem_dWEN     = ($urandom_range(0, 7) == 0);
    hif.mem_redirect = ($urandom_range(0, 7) == 0);
    hif.ex_memRead   = ($urandom_range(0, 2) == 0);
    hif.ex_rd        = 5'($urandom_range(0, 3));
    hif.id_rs        = 5'($urandom_range(0, 3));
    hif.id_rt        = 5'($urandom_range(0, 3));
    hif.id_usesRt    = $urandom_range(0, 1) == 1;
    hif.wb_halt      = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    nRST = 1'b1;
    model_reset();
    idle_inputs();
    #2;
    do_reset("reset");

    // Load-use bubble, then free flow.
    hif.ex_memRead = 1'b1; hif.ex_rd = 5'd8; hif.id_rs = 5'd8;
    cycle("lu");
    check("lu_ctrl_const", 32'(obs_ctrl()), 32'h3A);
    check("lu_stall_one", 32'(hif.stall_cnt), 32'd1);
    hif.ex_memRead = 1'b0;
    cycle("lu_after");

    // Load-use qualifiers: r0 never stalls, rt only when it is read.
    hif.ex_memRead = 1'b1; hif.ex_rd = 5'd0; hif.id_rs = 5'd0;
    cycle("lu_r0");
    hif.ex_rd = 5'd5; hif.id_rs = 5'd1; hif.id_rt = 5'd5; hif.id_usesRt = 1'b0;
    cycle("lu_rt_unused");
    hif.id_usesRt = 1'b1;
    cycle("lu_rt_used");
    idle_inputs();

    // Data-memory wait: three frozen cycles, then completion.
    do_reset("dw_reset");
    hif.mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) cycle("dwait");
    check("dwait_stall_three", 32'(hif.stall_cnt), 32'd3);
    hif.dhit = 1'b1;
    cycle("dwait_hit");
    check("dwait_stall_hold", 32'(hif.stall_cnt), 32'd3);
    idle_inputs();

    // Watchdog: set after the fourth waiting cycle, sticky until reset.
    do_reset("tmo_reset");
    hif.mem_dWEN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle("tmo");
      check("tmo_flag", 32'(hif.mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    hif.dhit = 1'b1;
    cycle("tmo_hit");
    idle_inputs();
    cycle("tmo_run");
    check("tmo_sticky", 32'(hif.mem_timeout), 32'd1);
    do_reset("tmo_clear");

    // Redirect squashes a simultaneous load-use and ignores the fetch miss.
    hif.mem_redirect = 1'b1; hif.ex_memRead = 1'b1; hif.ex_rd = 5'd8;
    hif.id_rs = 5'd8; hif.ihit = 1'b0;
    cycle("redir");
    check("redir_flush_one", 32'(hif.flush_cnt), 32'd1);
    check("redir_stall_zero", 32'(hif.stall_cnt), 32'd0);
    idle_inputs();

    // Halt wins over a data stall, then drains forever until reset.
    do_reset("halt_reset");
    hif.wb_halt = 1'b1; hif.mem_dREN = 1'b1;
    cycle("halt");
    check("halt_set", 32'(hif.halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      random_inputs();
      hif.wb_halt = 1'b0;
      cycle("halt_hold");
    end
    do_reset("halt_clear");
    idle_inputs();
    cycle("halt_run");

    // Stall counter saturation under a long fetch miss.
    do_reset("sat_reset");
    hif.ihit = 1'b0;
    for (int i = 0; i < 20; i++) cycle("sat");
    check("sat_stall_max", 32'(hif.stall_cnt), 32'd15);
    idle_inputs();

    // Random traffic with occasional resets.
    do_reset("rnd_reset");
    for (int i = 0; i < 800; i++) begin
      random_inputs();
      if ($urandom_range(0, 31) == 0) do_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the 5-stage MIPS datapath.
- Decides each cycle the PC enable plus the enable and flush of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Covers load-use bubbles (the EX-stage forwarding network cannot resolve these), instruction-miss bubbles, data-memory wait freezes, branch/jump redirect flushes and halt drain.
- Tracks stall and flush statistics and a data-memory watchdog.

Parameters:
- CNT_W, 16, width of the saturating performance counters.
- DWAIT_TIMEOUT, 255, consecutive DWAIT cycles before mem_timeout is raised (1..2^CNT_W-1).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access in MEM completes this cycle.
- mem_dREN  in  1  MEM-stage instruction reads data memory.
- mem_dWEN  in  1  MEM-stage instruction writes data memory.
- mem_redirect  in  1  branch taken or jump resolved in MEM.
- ex_memRead  in  1  EX-stage instruction is a load.
- ex_rd  in  5  EX-stage destination register.
- id_rs  in  5  ID-stage source rs.
- id_rt  in  5  ID-stage source rt.
- id_usesRt  in  1  ID-stage instruction reads rt.
- wb_halt  in  1  halt instruction in WB.
- pc_en  out  1  PC register load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous latch clear (to NOP); flush overrides enable inside the latch.
- halted  out  1  sticky, registered.
- mem_timeout  out  1  sticky, registered.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (async, nRST low):
  - state=RUN; halted=0, mem_timeout=0, stall_cnt=0, flush_cnt=0, dwait_cnt=0.
  - Combinational outputs follow the RUN equations.
- States: RUN, DWAIT, HALT. Outputs are combinational from state and inputs; state and counters are registered.
- Derived signals:
  - dstall = (mem_dREN | mem_dWEN) & ~dhit.
  - lu = ex_memRead & ex_rd!=0 & (ex_rd==id_rs | (id_usesRt & ex_rd==id_rt)).
- RUN/DWAIT action, evaluated in strict priority order:
  1. wb_halt: all en=0, pc_en=0, no flush; next=HALT.
  2. dstall: all en=0, pc_en=0, no flush (full freeze); stall_cnt++; next=DWAIT.
  3. mem_redirect: all en=1, pc_en=1, ifid_flush=idex_flush=exmem_flush=1; flush_cnt++; next=RUN. Applies regardless of ihit.
  4. lu: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1 (bubble), exmem_en=memwb_en=1; stall_cnt++; next=RUN.
  5. ~ihit: pc_en=0, ifid_en=1 with ifid_flush=1, downstream en=1; stall_cnt++; next=RUN.
  6. Otherwise: all en=1, pc_en=1, no flush; next=RUN.
- DWAIT:
  - dwait_cnt increments each cycle spent in DWAIT without dhit.
  - When dwait_cnt reaches DWAIT_TIMEOUT, mem_timeout is set and stays set until reset; state remains DWAIT.
  - dhit in DWAIT: priorities 3..6 apply in that same cycle, next=RUN, dwait_cnt cleared.
  - Entering RUN always clears dwait_cnt.
- HALT: all en=0, pc_en=0, no flush. halted=1 from the first HALT cycle. Counters frozen. Exit only by reset.
- Counters saturate at 2^CNT_W-1; no wrap.
- Reset mid-DWAIT or mid-HALT: immediate return to RUN, counters and sticky flags cleared.
- lu with ex_rd=0 never stalls. A simultaneous redirect squashes the load-use stall, since the ID instruction is flushed.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=8, id_rs=8, ihit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1; next cycle all en=1.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 full-freeze cycles, state DWAIT, stall_cnt=3; dhit cycle all en=1, state RUN.
- Timeout: DWAIT_TIMEOUT=4, dhit held 0 for 10 cycles -> mem_timeout=1 after the 4th DWAIT cycle, still 1 after dhit and after returning to RUN; cleared only by nRST.
- Redirect vs load-use: mem_redirect=1, lu=1, ihit=0 in the same cycle -> pc_en=1, three flushes=1, flush_cnt=1, stall_cnt unchanged.
- Halt: wb_halt=1 with dstall=1 -> freeze, halted=1 next edge; 20 further cycles with all en=0; nRST pulse low -> halted=0, state RUN.
- Saturation: CNT_W=4, hold ihit=0 for 20 cycles -> stall_cnt stops at 15; ifid_flush=1 in every one of those cycles.
